// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the ADC snapshot capture buffer.
// Sample (ch, smp) of the packed ADC vector lives at sample_offset(ch, smp, NSAMP, NBITS).
package adc_capture_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_ARMED = 3'd2,
      ST_POST  = 3'd3,
      ST_DONE  = 3'd4,
      ST_READ  = 3'd5
   } cap_state_e;

   function automatic int sample_offset(input int ch, input int smp, input int nsamp, input int nbits);
      return nbits * nsamp * ch + nbits * smp;
   endfunction

endpackage

// File: rtl/adc_capture_ram.sv
// Simple dual-port snapshot RAM: one full ADC clock-word per entry, registered read port.
module adc_capture_ram #(
   parameter int WIDTH = 768,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/adc_capture_buffer.sv
// Triggered snapshot of all ADC channels with pre-trigger history, replayed for one
// channel as an AXI4-Stream burst of DEPTH clock-words.
module adc_capture_buffer
   import adc_capture_pkg::*;
#(
   parameter int NCHAN      = 8,
   parameter int NSAMP      = 8,
   parameter int NBITS      = 12,
   parameter int DEPTH_LOG2 = 10,
   parameter int PRETRIG    = 256
) (
   input  logic                       aclk,
   input  logic                       aclk_rst,
   input  logic [NSAMP*NCHAN*NBITS-1:0] adc_dout_i,
   input  logic                       arm_i,
   input  logic                       trig_i,
   input  logic [$clog2(NCHAN)-1:0]   rd_chan_i,
   input  logic                       rd_start_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic [NSAMP*NBITS-1:0]     m_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tlast,
   output cap_state_e                 state_dbg
);

   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int VEC_W  = NSAMP * NCHAN * NBITS;
   localparam int WORD_W = NSAMP * NBITS;
   localparam int CHAN_W = $clog2(NCHAN);
   localparam int CW     = DEPTH_LOG2 + 1;

   localparam logic [CW-1:0]         PRE_CNT  = CW'(PRETRIG);
   localparam logic [CW-1:0]         POST_CNT = CW'(DEPTH - PRETRIG - 1);
   localparam logic [CW-1:0]         LAST_CNT = CW'(DEPTH - 1);
   localparam logic [CW-1:0]         FULL_CNT = CW'(DEPTH);
   localparam logic [DEPTH_LOG2-1:0] PRE_A    = DEPTH_LOG2'(PRETRIG);

   cap_state_e              state;
   logic [DEPTH_LOG2-1:0]   wptr, taddr, rd_addr, start_addr, ram_raddr;
   logic [CW-1:0]           cnt, cnt_inc, rd_issued, rd_idx;
   logic [CHAN_W-1:0]       rd_chan;
   logic [VEC_W-1:0]        ram_q;
   logic [WORD_W-1:0]       chan_word;
   logic                    ram_q_valid, ram_q_last;
   logic                    wr_en, rd_go, rd_more, out_ready, ram_re;

   assign wr_en      = (state == ST_FILL) || (state == ST_ARMED) || (state == ST_POST);
   assign cnt_inc    = cnt + 1'b1;
   assign start_addr = taddr - PRE_A;
   assign rd_go      = (state == ST_DONE) && rd_start_i && !arm_i;
   assign rd_more    = (rd_issued != FULL_CNT);

   // m_axis: a beat transfers on a cycle with tvalid && tready; while tvalid && !tready,
   // tdata/tlast hold. The RAM read register acts as the one-entry skid behind the output.
   assign out_ready  = !m_axis_tvalid || m_axis_tready;
   assign ram_re     = rd_go || ((state == ST_READ) && rd_more && (!ram_q_valid || out_ready));
   assign ram_raddr  = (state == ST_READ) ? rd_addr : start_addr;
   assign rd_idx     = rd_go ? '0 : rd_issued;

   assign busy_o    = wr_en;
   assign done_o    = (state == ST_DONE) || (state == ST_READ);
   assign state_dbg = state;

   adc_capture_ram #(
      .WIDTH (VEC_W),
      .AW    (DEPTH_LOG2)
   ) u_ram (
      .clk   (aclk),
      .we    (wr_en),
      .waddr (wptr),
      .wdata (adc_dout_i),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_q)
   );

   always_comb begin
      chan_word = '0;
      for (int c = 0; c < NCHAN; c++) begin
         if (rd_chan == CHAN_W'(c)) chan_word = ram_q[sample_offset(c, 0, NSAMP, NBITS) +: WORD_W];
      end
   end

   always_ff @(posedge aclk) begin
      if (aclk_rst) begin
         state         <= ST_IDLE;
         wptr          <= '0;
         taddr         <= '0;
         cnt           <= '0;
         rd_addr       <= '0;
         rd_issued     <= '0;
         rd_chan       <= '0;
         ram_q_valid   <= 1'b0;
         ram_q_last    <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
      end else begin
         if (wr_en) wptr <= wptr + 1'b1;

         case (state)
            ST_IDLE: begin
               if (arm_i) begin
                  state <= ST_FILL;
                  cnt   <= '0;
               end
            end
            ST_FILL: begin
               cnt <= cnt_inc;
               if (cnt_inc == PRE_CNT || PRE_CNT == '0) state <= ST_ARMED;
            end
            ST_ARMED: begin
               if (trig_i) begin
                  taddr <= wptr;
                  cnt   <= '0;
                  state <= (POST_CNT == '0) ? ST_DONE : ST_POST;
               end
            end
            ST_POST: begin
               cnt <= cnt_inc;
               if (cnt_inc == POST_CNT) state <= ST_DONE;
            end
            ST_DONE: begin
               if (arm_i) begin
                  state <= ST_FILL;
                  cnt   <= '0;
               end else if (rd_start_i) begin
                  state   <= ST_READ;
                  rd_chan <= (int'(rd_chan_i) < NCHAN) ? rd_chan_i : '0;
               end
            end
            ST_READ: begin
               if (m_axis_tvalid && m_axis_tready && m_axis_tlast) state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase

         // The first word is fetched on the rd_start_i edge so tvalid rises two cycles later.
         if (ram_re) begin
            ram_q_valid <= 1'b1;
            ram_q_last  <= (rd_idx == LAST_CNT);
            rd_issued   <= rd_idx + 1'b1;
            rd_addr     <= ram_raddr + 1'b1;
         end else if (out_ready) begin
            ram_q_valid <= 1'b0;
         end

         if (state == ST_READ && out_ready) begin
            m_axis_tvalid <= ram_q_valid;
            m_axis_tlast  <= ram_q_valid && ram_q_last;
            if (ram_q_valid) m_axis_tdata <= chan_word;
         end
      end
   end

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed-plus-random bench for adc_capture_buffer: two builds (PRETRIG=4 and PRETRIG=0)
// share stimulus; expected bursts come from the capture-window rule applied to the word index.
module tb_adc_capture_buffer;
   import adc_capture_pkg::*;

   localparam int NCHAN = 8;
   localparam int NSAMP = 8;
   localparam int NBITS = 12;
   localparam int DL    = 4;
   localparam int DEPTH = 16;
   localparam int VEC_W = NCHAN * NSAMP * NBITS;
   localparam int W     = NSAMP * NBITS;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [VEC_W-1:0] adc = '0;
   logic             arm = 1'b0, trig = 1'b0, rd_start = 1'b0, tready = 1'b1;
   logic [2:0]       rd_chan = '0;

   logic             busy4, done4, tvalid4, tlast4, busy0, done0, tvalid0, tlast0;
   logic [W-1:0]     tdata4, tdata0;
   cap_state_e       st4, st0;

   int               n_checks = 0;
   int               n_err = 0;
   int               n;
   logic [W-1:0]     exp_q4[$];
   logic [W-1:0]     exp_q0[$];

   always #5 clk = ~clk;

   adc_capture_buffer #(.NCHAN(NCHAN), .NSAMP(NSAMP), .NBITS(NBITS), .DEPTH_LOG2(DL), .PRETRIG(4)) u_dut4 (
      .aclk(clk), .aclk_rst(rst), .adc_dout_i(adc), .arm_i(arm), .trig_i(trig),
      .rd_chan_i(rd_chan), .rd_start_i(rd_start), .busy_o(busy4), .done_o(done4),
      .m_axis_tdata(tdata4), .m_axis_tvalid(tvalid4), .m_axis_tready(tready),
      .m_axis_tlast(tlast4), .state_dbg(st4));

   adc_capture_buffer #(.NCHAN(NCHAN), .NSAMP(NSAMP), .NBITS(NBITS), .DEPTH_LOG2(DL), .PRETRIG(0)) u_dut0 (
      .aclk(clk), .aclk_rst(rst), .adc_dout_i(adc), .arm_i(arm), .trig_i(trig),
      .rd_chan_i(rd_chan), .rd_start_i(rd_start), .busy_o(busy0), .done_o(done0),
      .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tready(tready),
      .m_axis_tlast(tlast0), .state_dbg(st0));

   // Stimulus word n: channel c, sample s = {c[3:0], n[7:0]} + s (mod 4096).
   function automatic logic [W-1:0] chan_word(input int ch, input int idx);
      logic [W-1:0] v;
      logic [7:0]   nb;
      logic [3:0]   cb;
      v  = '0;
      nb = idx[7:0];
      cb = ch[3:0];
      for (int s = 0; s < NSAMP; s++) v[NBITS*s +: NBITS] = {cb, nb} + 12'(s);
      return v;
   endfunction

   function automatic logic [VEC_W-1:0] adc_word(input int idx);
      logic [VEC_W-1:0] v;
      for (int c = 0; c < NCHAN; c++) v[W*c +: W] = chan_word(c, idx);
      return v;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Arm, stream words 0,1,2,... and stop once both builds report DONE (or at abort_n).
   task automatic capture(input int trig_n, input bit hold, input bit with_rd, input int abort_n,
                          output int t4, output int t0);
      int last4, last0, cyc;
      t4    = hold ? 4 : trig_n;
      t0    = hold ? 1 : trig_n;
      last4 = t4 - 4 + DEPTH - 1;
      last0 = t0 + DEPTH - 1;
      n = -1; adc = adc_word(n); arm = 1'b1; rd_start = with_rd; trig = hold;
      tick();
      arm = 1'b0; rd_start = 1'b0;
      chk("arm_enters_fill", st4, ST_FILL);
      chk("arm_busy", busy4, 1'b1);
      n = 0; cyc = 0;
      while (!(done4 && done0) && cyc < 200) begin
         adc  = adc_word(n);
         trig = hold || (n == trig_n);
         tick();
         if (n == 0) chk("pre0_fill_one_cycle", st0, ST_ARMED);
         if (n == 2) chk("fill_before_pretrig", st4, ST_FILL);
         if (n == 3) chk("armed_after_pretrig", st4, ST_ARMED);
         if (with_rd && n < 3) chk("arm_wins_no_tvalid", tvalid4, 1'b0);
         if (n == last4 - 1) chk("post_busy", busy4, 1'b1);
         if (n == last4) begin
            chk("post_done", done4, 1'b1);
            chk("post_not_busy", busy4, 1'b0);
         end
         if (n == last0) chk("pre0_done", done0, 1'b1);
         if (n == abort_n) break;
         n++; cyc++;
      end
      trig = 1'b0;
      chk("capture_bounded", cyc < 200, 1'b1);
   endtask

   task automatic readout(input int ch, input bit rnd, input int t4, input int t0);
      int           k, first_v;
      bit           stall4;
      logic [W-1:0] held4;
      logic         held_last;
      for (int b = 0; b < DEPTH; b++) begin
         exp_q4.push_back(chan_word(ch, t4 - 4 + b));
         exp_q0.push_back(chan_word(ch, t0 + b));
      end
      rd_chan = 3'(ch); rd_start = 1'b1; tready = 1'b1;
      tick();
      rd_start = 1'b0;
      k = 1; first_v = 0; stall4 = 1'b0; held4 = '0; held_last = 1'b0;
      while (exp_q4.size() > 0 && k < 300) begin
         tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (k == 1) chk("rd_first_cycle_idle", tvalid4, 1'b0);
         if (tvalid4 && first_v == 0) begin
            first_v = k;
            chk("rd_first_valid_latency", k, 2);
         end
         if (stall4) begin
            chk("stall_valid_held", tvalid4, 1'b1);
            chk("stall_data_held", tdata4, held4);
            chk("stall_last_held", tlast4, held_last);
         end
         if (tvalid4 && tready) begin
            chk("beat_data", tdata4, exp_q4[0]);
            chk("beat_last", tlast4, exp_q4.size() == 1);
            void'(exp_q4.pop_front());
         end
         if (tvalid0 && tready && exp_q0.size() > 0) begin
            chk("pre0_beat_data", tdata0, exp_q0[0]);
            chk("pre0_beat_last", tlast0, exp_q0.size() == 1);
            void'(exp_q0.pop_front());
         end
         stall4    = tvalid4 && !tready;
         held4     = tdata4;
         held_last = tlast4;
         tick();
         k++;
      end
      chk("read_all_beats", exp_q4.size(), 0);
      chk("pre0_read_all_beats", exp_q0.size(), 0);
      if (!rnd) chk("read_no_bubbles", k, DEPTH + 2);
      chk("read_tvalid_drops", tvalid4, 1'b0);
      chk("read_back_to_done", st4, ST_DONE);
      chk("read_done_flag", done4, 1'b1);
      chk("pre0_back_to_done", done0, 1'b1);
      exp_q4.delete();
      exp_q0.delete();
      tready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t4, t0, tr;

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_state", st4, ST_IDLE);
      chk("rst_busy", busy4, 1'b0);
      chk("rst_done", done4, 1'b0);
      chk("rst_tvalid", tvalid4, 1'b0);
      chk("rst_tlast", tlast4, 1'b0);
      chk("rst_tdata", tdata4, '0);

      // rd_start in IDLE is ignored
      rd_start = 1'b1; tick(); rd_start = 1'b0; tick();
      chk("idle_rd_start_ignored", tvalid4, 1'b0);
      chk("idle_rd_start_state", st4, ST_IDLE);

      // Basic capture, then repeated readouts of the same snapshot
      capture(20, 1'b0, 1'b0, -1, t4, t0);
      readout(3, 1'b0, t4, t0);
      readout($urandom_range(0, NCHAN - 1), 1'b0, t4, t0);

      // Trigger held from arm onward
      capture(0, 1'b1, 1'b0, -1, t4, t0);
      readout(5, 1'b0, t4, t0);

      // Write pointer wraps before the trigger
      capture(37, 1'b0, 1'b0, -1, t4, t0);
      readout(0, 1'b0, t4, t0);

      // Random trigger position, backpressure on channel 7
      tr = $urandom_range(8, 60);
      capture(tr, 1'b0, 1'b0, -1, t4, t0);
      readout(7, 1'b1, t4, t0);

      // arm_i and rd_start_i together in DONE: arm wins
      capture(30, 1'b0, 1'b1, -1, t4, t0);
      readout($urandom_range(0, NCHAN - 1), 1'b1, t4, t0);

      // Reset during POST
      capture(10, 1'b0, 1'b0, 16, t4, t0);
      chk("pre_abort_busy", busy4, 1'b1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("abort_post_busy", busy4, 1'b0);
      chk("abort_post_done", done4, 1'b0);
      chk("abort_post_tvalid", tvalid4, 1'b0);
      chk("abort_post_pre0_busy", busy0, 1'b0);
      rd_start = 1'b1; tick(); rd_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort_post_rd_ignored", tvalid4, 1'b0);
      end

      // Reset during READ
      capture(25, 1'b0, 1'b0, -1, t4, t0);
      rd_chan = 3'd2; rd_start = 1'b1; tready = 1'b1; tick(); rd_start = 1'b0;
      repeat (6) tick();
      chk("mid_read_tvalid", tvalid4, 1'b1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("abort_read_tvalid", tvalid4, 1'b0);
      chk("abort_read_done", done4, 1'b0);
      chk("abort_read_busy", busy4, 1'b0);
      chk("abort_read_pre0_tvalid", tvalid0, 1'b0);
      rd_start = 1'b1; tick(); rd_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort_read_rd_ignored", tvalid4, 1'b0);
      end
      chk("abort_read_idle", st4, ST_IDLE);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
